// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship repair array: per-station state
// encodings and the constants of the shared random source.
package nexys_starship_pkg;

  // One-hot station states. Any other value is treated as corrupt and
  // steers the station back to ST_INIT on the next edge.
  typedef enum logic [2:0] {
    ST_INIT    = 3'b001,
    ST_WORKING = 3'b010,
    ST_REPAIR  = 3'b100
  } stn_state_e;

  // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One right shift of the Galois register. The polynomial is maximal
  // length, so a non-zero seed can never reach the all-zero lockup state.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/nexys_starship_repair_channel.sv
// One repairable station: INIT/WORKING/REPAIR FSM, repair timer, cooldown
// counter, repair-button edge detector and the captured combo.
module nexys_starship_repair_channel
  import nexys_starship_pkg::*;
#(
  parameter int COMBO_W  = 4,
  parameter int COOLDOWN = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               play_flag,
  input  logic               game_over,
  input  logic               break_req,
  input  logic [COMBO_W-1:0] break_combo,
  input  logic [COMBO_W-1:0] hex_combo,
  input  logic               repair_btn,
  output logic               broken,
  output logic [COMBO_W-1:0] req_combo,
  output logic               st_init,
  output logic               st_working,
  output logic               st_repair,
  output logic               wrong_try,
  output logic               timeout_hit
);

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int TM_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  stn_state_e         state_q, state_d;
  logic               broken_q, broken_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [CD_W-1:0]    cool_q, cool_d;
  logic [TM_W-1:0]    timer_q, timer_d;
  logic               btn_q, btn_d;
  logic               btn_rise;

  // Station register bank; reset aborts any repair in progress at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      broken_q <= 1'b0;
      combo_q  <= '0;
      cool_q   <= '0;
      timer_q  <= '0;
      btn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      broken_q <= broken_d;
      combo_q  <= combo_d;
      cool_q   <= cool_d;
      timer_q  <= timer_d;
      btn_q    <= btn_d;
    end
  end

  // Next-state logic; game_over wins over break and repair in the same cycle.
  always_comb begin
    state_d   = state_q;
    broken_d  = broken_q;
    combo_d   = combo_q;
    cool_d    = cool_q;
    timer_d   = timer_q;
    btn_d     = repair_btn;
    wrong_try = 1'b0;
    // Only a 0->1 transition is an attempt, so a held button tries once.
    btn_rise  = repair_btn && !btn_q;
    if (game_over) begin
      state_d  = ST_INIT;
      broken_d = 1'b0;
      cool_d   = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          broken_d = 1'b0;
          cool_d   = '0;
          timer_d  = '0;
          if (play_flag) state_d = ST_WORKING;
        end
        ST_WORKING: begin
          timer_d = '0;
          if (break_req && (cool_q == '0)) begin
            state_d  = ST_REPAIR;
            broken_d = 1'b1;
            combo_d  = break_combo;
          end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
          end
        end
        ST_REPAIR: begin
          if (timer_q != TM_W'(TIMEOUT)) timer_d = timer_q + 1'b1;
          if (btn_rise) begin
            if (hex_combo == combo_q) begin
              state_d  = ST_WORKING;
              broken_d = 1'b0;
              cool_d   = CD_W'(COOLDOWN);
              timer_d  = '0;
            end else begin
              wrong_try = 1'b1;
            end
          end
        end
        default: begin
          state_d  = ST_INIT;
          broken_d = 1'b0;
          cool_d   = '0;
          timer_d  = '0;
        end
      endcase
    end
  end

  // The timer reaching its ceiling while still in REPAIR raises the alarm.
  assign timeout_hit = (state_d == ST_REPAIR) && (timer_d == TM_W'(TIMEOUT));

  assign broken     = broken_q;
  assign req_combo  = combo_q;
  assign st_init    = (state_q == ST_INIT);
  assign st_working = (state_q == ST_WORKING);
  assign st_repair  = (state_q == ST_REPAIR);

endmodule

// File: rtl/nexys_starship_repair_array.sv
// Starship repair array top: shared LFSR, single-candidate break selection,
// NUM_STN repair channels, and the merged wrong-combo / timeout indications.
module nexys_starship_repair_array
  import nexys_starship_pkg::*;
#(
  parameter int NUM_STN      = 4,
  parameter int COMBO_W      = 4,
  parameter int BREAK_THRESH = 25,
  parameter int COOLDOWN     = 64,
  parameter int TIMEOUT      = 1024
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       play_flag,
  input  logic                       game_over,
  input  logic [COMBO_W-1:0]         hex_combo,
  input  logic [NUM_STN-1:0]         repair_btn,
  output logic [NUM_STN-1:0]         broken,
  output logic [NUM_STN*COMBO_W-1:0] req_combo,
  output logic [NUM_STN-1:0]         q_Init,
  output logic [NUM_STN-1:0]         q_Working,
  output logic [NUM_STN-1:0]         q_Repair,
  output logic                       wrong_pulse,
  output logic                       timeout_flag
);

  localparam int          SEL_W    = (NUM_STN > 1) ? $clog2(NUM_STN) : 1;
  localparam logic [8:0]  THRESH_V = 9'(BREAK_THRESH);

  logic [15:0]        lfsr_q, lfsr_d;
  logic               wrong_pulse_q, wrong_pulse_d;
  logic               timeout_flag_q, timeout_flag_d;
  logic [SEL_W-1:0]   cand;
  logic               break_en;
  logic [NUM_STN-1:0] break_req;
  logic [NUM_STN-1:0] wrong_try;
  logic [NUM_STN-1:0] timeout_hit;

  // Shared random source and the merged status flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr_q         <= LFSR_SEED;
      wrong_pulse_q  <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      wrong_pulse_q  <= wrong_pulse_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  // Pick at most one break candidate per cycle and merge channel events.
  always_comb begin
    lfsr_d    = lfsr_next(lfsr_q);
    cand      = (NUM_STN > 1) ? lfsr_q[8 +: SEL_W] : '0;
    break_en  = ({1'b0, lfsr_q[7:0]} < THRESH_V) && !game_over;
    break_req = '0;
    for (int i = 0; i < NUM_STN; i++) begin
      break_req[i] = break_en && (cand == SEL_W'(i));
    end
    wrong_pulse_d  = |wrong_try;
    timeout_flag_d = game_over ? 1'b0 : (timeout_flag_q | (|timeout_hit));
  end

  for (genvar g = 0; g < NUM_STN; g++) begin : g_stn
    nexys_starship_repair_channel #(
      .COMBO_W (COMBO_W),
      .COOLDOWN(COOLDOWN),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk        (Clk),
      .rst_n      (Reset),
      .play_flag  (play_flag),
      .game_over  (game_over),
      .break_req  (break_req[g]),
      .break_combo(lfsr_q[15 -: COMBO_W]),
      .hex_combo  (hex_combo),
      .repair_btn (repair_btn[g]),
      .broken     (broken[g]),
      .req_combo  (req_combo[g*COMBO_W +: COMBO_W]),
      .st_init    (q_Init[g]),
      .st_working (q_Working[g]),
      .st_repair  (q_Repair[g]),
      .wrong_try  (wrong_try[g]),
      .timeout_hit(timeout_hit[g])
    );
  end

  assign wrong_pulse  = wrong_pulse_q;
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_nexys_starship_repair_array.sv
// Bench for nexys_starship_repair_array: a behavioural model predicts every
// cycle's outputs into exp_q; scenario tasks pop and compare, and also check
// the headline behaviours against fixed expected values.
module tb_nexys_starship_repair_array;

  localparam int NS    = 4;
  localparam int CW    = 4;
  localparam int THR   = 25;
  localparam int COOL  = 64;
  localparam int TMO   = 1024;
  localparam int OBS_W = NS*CW + 2 + 4*NS;
  localparam int S_INIT = 0, S_WORK = 1, S_REP = 2;
  localparam logic [OBS_W-1:0] RST_OBS =
    {{(NS*CW){1'b0}}, 2'b00, {NS{1'b0}}, {NS{1'b0}}, {NS{1'b1}}, {NS{1'b0}}};

  // ---------------- clock / reset / DUT ----------------
  logic             Clk = 1'b0;
  logic             Reset;
  logic             play_flag, game_over;
  logic [CW-1:0]    hex_combo;
  logic [NS-1:0]    repair_btn;
  logic [NS-1:0]    broken, q_Init, q_Working, q_Repair;
  logic [NS*CW-1:0] req_combo;
  logic             wrong_pulse, timeout_flag;
  logic [OBS_W-1:0] obs;

  always #5 Clk = ~Clk;

  nexys_starship_repair_array #(
    .NUM_STN(NS), .COMBO_W(CW), .BREAK_THRESH(THR), .COOLDOWN(COOL), .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .hex_combo(hex_combo), .repair_btn(repair_btn), .broken(broken),
    .req_combo(req_combo), .q_Init(q_Init), .q_Working(q_Working),
    .q_Repair(q_Repair), .wrong_pulse(wrong_pulse), .timeout_flag(timeout_flag)
  );

  assign obs = {req_combo, timeout_flag, wrong_pulse, q_Repair, q_Working, q_Init, broken};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model / scoreboard ----------------
  int            m_st[NS];
  int            m_cool[NS];
  int            m_tmr[NS];
  logic [CW-1:0] m_combo[NS];
  logic [NS-1:0] m_btn;
  logic [15:0]   m_lfsr;
  logic          m_tflag, m_wp;
  logic [OBS_W-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_st[i] = S_INIT; m_cool[i] = 0; m_tmr[i] = 0; m_combo[i] = '0;
    end
    m_btn = '0; m_lfsr = 16'hACE1; m_tflag = 1'b0; m_wp = 1'b0;
  endtask

  // Advance the model by one edge using the inputs now applied; push the
  // outputs the DUT must show after that edge.
  task automatic model_step();
    logic [15:0] l;
    int cand;
    bit fire, wr, hit, rise;
    logic [NS-1:0] e_b, e_i, e_w, e_r;
    logic [NS*CW-1:0] e_c;
    if (!Reset) model_reset();
    else begin
      l = m_lfsr;
      cand = int'(l[9:8]);
      fire = (int'(l[7:0]) < THR) && !game_over;
      wr = 0; hit = 0;
      for (int i = 0; i < NS; i++) begin
        rise = repair_btn[i] && !m_btn[i];
        if (game_over) begin
          m_st[i] = S_INIT; m_cool[i] = 0; m_tmr[i] = 0;
        end else if (m_st[i] == S_INIT) begin
          if (play_flag) m_st[i] = S_WORK;
        end else if (m_st[i] == S_WORK) begin
          if (fire && cand == i && m_cool[i] == 0) begin
            m_st[i] = S_REP; m_combo[i] = l[15:12]; m_tmr[i] = 0;
          end else if (m_cool[i] > 0) m_cool[i]--;
        end else begin
          if (rise && hex_combo == m_combo[i]) begin
            m_st[i] = S_WORK; m_cool[i] = COOL;
          end else begin
            if (rise) wr = 1;
            if (m_tmr[i] < TMO) m_tmr[i]++;
            if (m_tmr[i] == TMO) hit = 1;
          end
        end
      end
      m_btn   = repair_btn;
      m_lfsr  = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      m_tflag = game_over ? 1'b0 : (m_tflag | hit);
      m_wp    = wr;
    end
    for (int i = 0; i < NS; i++) begin
      e_b[i] = (m_st[i] == S_REP);
      e_r[i] = (m_st[i] == S_REP);
      e_w[i] = (m_st[i] == S_WORK);
      e_i[i] = (m_st[i] == S_INIT);
      e_c[i*CW +: CW] = m_combo[i];
    end
    exp_q.push_back({e_c, m_tflag, m_wp, e_r, e_w, e_i, e_b});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit any_rep();
    for (int i = 0; i < NS; i++) if (m_st[i] == S_REP) return 1'b1;
    return 1'b0;
  endfunction

  // Next edge will break a working, cooled-down station (excluding 'skip').
  function automatic bit break_next(input int skip);
    int c;
    c = int'(m_lfsr[9:8]);
    return (int'(m_lfsr[7:0]) < THR) && (c != skip) && (m_st[c] == S_WORK) && (m_cool[c] == 0);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [OBS_W-1:0] e;
    Reset = 1'b1; play_flag = 0; game_over = 0; hex_combo = '0; repair_btn = '0;
    #2 Reset = 1'b0;
    #2;
    n_checks++;
    if (obs !== RST_OBS) begin n_fail++; $display("FAIL reset_async: dut=%h expected=%h", obs, RST_OBS); end
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tick(); e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_hold: dut=%h expected=%h", obs, e); end
    end
    Reset = 1'b1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e || obs !== RST_OBS) begin n_fail++; $display("FAIL reset_release: dut=%h expected=%h", obs, RST_OBS); end
  endtask

  task automatic test_play();
    logic [OBS_W-1:0] e;
    play_flag = 1'b1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL play_track: dut=%h expected=%h", obs, e); end
    play_flag = 1'b0;
    n_checks++;
    if (q_Working !== 4'hF || broken !== 4'h0)
      begin n_fail++; $display("FAIL play_working: q_Working=%h broken=%h expected F/0", q_Working, broken); end
  endtask

  task automatic test_repair();
    logic [OBS_W-1:0] e;
    bit found = 0, bad = 0;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (m_st[2] == S_REP && m_combo[2] == 4'hA) found = 1;
      else begin
        game_over = any_rep(); play_flag = !game_over;
        tick(); e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL repair_search: dut=%h expected=%h", obs, e); end
      end
    end
    game_over = 0; play_flag = 0;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL repair_budget: station 2 combo A break not seen, expected within budget"); return; end
    n_checks++;
    if (broken[2] !== 1'b1 || req_combo[11:8] !== 4'hA)
      begin n_fail++; $display("FAIL repair_armed: broken2=%b slot=%h expected 1/A", broken[2], req_combo[11:8]); end
    hex_combo = 4'hA; repair_btn = 4'b0100;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL repair_edge: dut=%h expected=%h", obs, e); end
    n_checks++;
    if (broken[2] !== 1'b0 || q_Working[2] !== 1'b1 || wrong_pulse !== 1'b0)
      begin n_fail++; $display("FAIL repair_done: broken2=%b work2=%b wrong=%b expected 0/1/0", broken[2], q_Working[2], wrong_pulse); end
    repair_btn = '0;
    for (int k = 0; k < COOL; k++) begin
      tick(); e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL cooldown_track: dut=%h expected=%h", obs, e); end
      if (broken[2] !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL cooldown_hold: station 2 broke again, expected none for %0d cycles", COOL); end
  endtask

  task automatic test_wrong_combo();
    logic [OBS_W-1:0] e;
    int s = -1;
    bit bad = 0;
    for (int c = 0; c < 20000 && s < 0; c++) begin
      for (int i = 0; i < NS; i++) if (m_st[i] == S_REP && m_combo[i] == 4'h3) s = i;
      if (s < 0) begin
        game_over = any_rep(); play_flag = !game_over;
        tick(); e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL wrong_search: dut=%h expected=%h", obs, e); end
      end
    end
    game_over = 0; play_flag = 0;
    n_checks++;
    if (s < 0) begin n_fail++; $display("FAIL wrong_budget: combo 3 break not seen, expected within budget"); return; end
    hex_combo = 4'h5; repair_btn = 4'(1 << s);
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL wrong_edge: dut=%h expected=%h", obs, e); end
    n_checks++;
    if (wrong_pulse !== 1'b1 || broken[s] !== 1'b1)
      begin n_fail++; $display("FAIL wrong_pulse: wrong=%b broken=%b expected 1/1", wrong_pulse, broken[s]); end
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL wrong_hold_track: dut=%h expected=%h", obs, e); end
      if (wrong_pulse !== 1'b0 || broken[s] !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL wrong_hold: extra pulse or repair while held, expected none"); end
    repair_btn = '0;
  endtask

  task automatic test_timeout();
    logic [OBS_W-1:0] e;
    bit found = 0, bad = 0;
    game_over = 1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL timeout_clear: dut=%h expected=%h", obs, e); end
    game_over = 0; play_flag = 1;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (any_rep()) found = 1;
      else begin
        tick(); e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL timeout_search: dut=%h expected=%h", obs, e); end
      end
    end
    play_flag = 0;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL timeout_budget: no break seen, expected within budget"); return; end
    for (int k = 1; k <= TMO + 5; k++) begin
      tick(); e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL timeout_track: dut=%h expected=%h", obs, e); end
      if (k == TMO - 1) begin
        n_checks++;
        if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL timeout_early: flag=%b at cycle %0d expected 0", timeout_flag, k); end
      end
      if (k == TMO) begin
        n_checks++;
        if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL timeout_set: flag=%b at cycle %0d expected 1", timeout_flag, k); end
      end
      if (k > TMO && timeout_flag !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL timeout_sticky: flag dropped, expected 1"); end
    game_over = 1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL timeout_over_track: dut=%h expected=%h", obs, e); end
    n_checks++;
    if (timeout_flag !== 1'b0 || q_Init !== 4'hF || broken !== 4'h0)
      begin n_fail++; $display("FAIL timeout_over: flag=%b init=%h broken=%h expected 0/F/0", timeout_flag, q_Init, broken); end
    game_over = 0;
  endtask

  task automatic test_gameover_break();
    logic [OBS_W-1:0] e;
    bit found = 0;
    play_flag = 1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL gob_play: dut=%h expected=%h", obs, e); end
    play_flag = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (break_next(-1)) found = 1;
      else begin
        tick(); e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL gob_search: dut=%h expected=%h", obs, e); end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL gob_budget: no qualifying break, expected within budget"); return; end
    game_over = 1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL gob_track: dut=%h expected=%h", obs, e); end
    n_checks++;
    if (q_Repair !== 4'h0 || q_Init !== 4'hF || broken !== 4'h0)
      begin n_fail++; $display("FAIL gob_override: rep=%h init=%h broken=%h expected 0/F/0", q_Repair, q_Init, broken); end
    game_over = 0;
  endtask

  task automatic test_repair_and_break();
    logic [OBS_W-1:0] e;
    int si = -1, sj = -1;
    play_flag = 1;
    for (int c = 0; c < 5000 && sj < 0; c++) begin
      if (si < 0) for (int i = 0; i < NS; i++) if (m_st[i] == S_REP) si = i;
      if (si >= 0 && break_next(si)) sj = int'(m_lfsr[9:8]);
      else begin
        tick(); e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL rab_search: dut=%h expected=%h", obs, e); end
      end
    end
    play_flag = 0;
    n_checks++;
    if (sj < 0) begin n_fail++; $display("FAIL rab_budget: setup not reached, expected within budget"); return; end
    hex_combo = m_combo[si]; repair_btn = 4'(1 << si);
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rab_track: dut=%h expected=%h", obs, e); end
    n_checks++;
    if (broken[si] !== 1'b0 || broken[sj] !== 1'b1)
      begin n_fail++; $display("FAIL rab_both: broken=%b (repaired %0d, broke %0d) expected repaired 0 / broke 1", broken, si, sj); end
    repair_btn = '0;
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] e;
    int k;
    for (int c = 0; c < 1500; c++) begin
      play_flag = ($urandom_range(0, 3) == 0);
      game_over = ($urandom_range(0, 299) == 0);
      k = int'($urandom_range(0, NS - 1));
      hex_combo = 4'($urandom_range(0, 15));
      if (m_st[k] == S_REP && $urandom_range(0, 1) == 1) hex_combo = m_combo[k];
      if ($urandom_range(0, 2) == 0) repair_btn = repair_btn ^ 4'(1 << k);
      tick(); e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL random_track: cycle %0d dut=%h expected=%h", c, obs, e); end
    end
    play_flag = 0; game_over = 0; repair_btn = '0; hex_combo = '0;
  endtask

  task automatic test_async_reset();
    logic [OBS_W-1:0] e;
    bit found = 0;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (m_st[1] == S_REP) found = 1;
      else begin
        game_over = any_rep(); play_flag = !game_over;
        tick(); e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL areset_search: dut=%h expected=%h", obs, e); end
      end
    end
    game_over = 0; play_flag = 0;
    n_checks++;
    if (!found || broken[1] !== 1'b1) begin n_fail++; $display("FAIL areset_setup: broken1=%b expected 1", broken[1]); return; end
    Reset = 1'b0;
    #2;
    n_checks++;
    if (obs !== RST_OBS) begin n_fail++; $display("FAIL areset_now: dut=%h expected=%h", obs, RST_OBS); end
    model_reset();
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL areset_hold: dut=%h expected=%h", obs, e); end
    Reset = 1'b1;
    tick(); e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL areset_release: dut=%h expected=%h", obs, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_play();
    test_repair();
    test_wrong_combo();
    test_timeout();
    test_gameover_break();
    test_repair_and_break();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nexys_starship_repair_array.md
NEXYS_STARSHIP_REPAIR_ARRAY -- requirements
Module: nexys_starship_repair_array

Interface
REQ-001 Parameter NUM_STN, default 4, number of repairable stations; power of two, 1..8.
REQ-002 Parameter COMBO_W, default 4, repair-combo width, 1..8.
REQ-003 Parameter BREAK_THRESH, default 25, break event when lfsr[7:0] < BREAK_THRESH.
REQ-004 Parameter COOLDOWN, default 64, cycles after a repair before that station may break again.
REQ-005 Parameter TIMEOUT, default 1024, cycles a station may stay in REPAIR before raising a timeout.
REQ-006 Clk  input  1  single system clock, all logic on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 play_flag  input  1  game-start request.
REQ-009 game_over  input  1  game-end request, highest priority.
REQ-010 hex_combo  input  COMBO_W  player-entered combo.
REQ-011 repair_btn  input  NUM_STN  per-station repair buttons, level, debounced upstream.
REQ-012 broken  output  NUM_STN  per-station broken flag.
REQ-013 req_combo  output  NUM_STN*COMBO_W  captured combo per station, station i at [i*COMBO_W +: COMBO_W].
REQ-014 q_Init, q_Working, q_Repair  output  NUM_STN each  one-hot per-station state bits.
REQ-015 wrong_pulse  output  1  one-cycle pulse on a wrong-combo attempt.
REQ-016 timeout_flag  output  1  sticky, set when any station exceeds TIMEOUT.

Function
REQ-017 Random source: one shared 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances every cycle, never zero.
REQ-018 Per station, 3 states: INIT, WORKING, REPAIR, one-hot; an illegal encoding SHALL return to INIT next cycle.
REQ-019 INIT: play_flag=1 -> WORKING next cycle; broken, cooldown, timer cleared.
REQ-020 Break selection: at most one station breaks per cycle; candidate index = lfsr[8 +: log2(NUM_STN)] (0 when NUM_STN=1).
REQ-021 Candidate breaks only if WORKING, cooldown = 0, lfsr[7:0] < BREAK_THRESH, and game_over=0.
REQ-022 On break: broken[i] <= 1, req_combo slot <= lfsr[15 -: COMBO_W], state -> REPAIR in the same edge; timer cleared.
REQ-023 REPAIR: a rising edge of repair_btn[i] (internally registered edge detect) with hex_combo == slot -> WORKING, broken[i] <= 0, cooldown <= COOLDOWN.
REQ-024 Rising edge with mismatched combo -> stays REPAIR, wrong_pulse = 1 for exactly one cycle (OR across stations).
REQ-025 A held button SHALL produce only one attempt; a new attempt requires release and re-press.
REQ-026 REPAIR timer increments each cycle, saturates at TIMEOUT; reaching TIMEOUT sets timeout_flag; station stays in REPAIR.
REQ-027 Cooldown decrements by 1 per WORKING cycle, saturating at 0.
REQ-028 game_over=1 -> every station INIT next cycle, broken cleared, timeout_flag cleared; overrides break and repair in the same cycle.
REQ-029 Repair of station i and break of a different station j in the same cycle SHALL both take effect.
REQ-030 req_combo slot holds its value until the next break of that station.

Reset
REQ-031 Reset=0: all stations INIT, broken=0, req_combo=0, wrong_pulse=0, timeout_flag=0, timers/cooldowns 0, LFSR=16'hACE1, edge-detect registers 0.
REQ-032 Reset asserted mid-repair SHALL abort immediately, asynchronously; release is synchronous to Clk.

Structure
REQ-033 State encodings, LFSR seed and tap mask SHALL live in shared package nexys_starship_pkg.
REQ-034 One sub-module nexys_starship_repair_channel (FSM, timer, cooldown, edge detect, combo register), instantiated NUM_STN times; LFSR and break selection stay in the top.

Verification
REQ-035 Reset release, play_flag pulse -> all q_Working=1 after 1 cycle, broken=0.
REQ-036 Force break on station 2 with lfsr slot combo 4'hA; hex_combo=4'hA, press repair_btn[2] -> broken[2]=0 next cycle, no break of station 2 for 64 cycles.
REQ-037 Station broken with combo 4'h3, press with hex_combo=4'h5 -> wrong_pulse high 1 cycle, broken stays 1; hold button 10 cycles -> no further pulses.
REQ-038 Leave station broken 1024 cycles -> timeout_flag=1 at cycle 1024, stays set; game_over -> cleared, all INIT.
REQ-039 game_over in the same cycle as a qualifying break -> no station enters REPAIR, all INIT.
REQ-040 Reset pulled low while station 1 in REPAIR -> outputs at reset values without waiting for a Clk edge.
